// File: rtl/bcd_refresh_scheduler_if.sv
// Request/operand/result bundle between display channels and the shared BCD engine.
interface bcd_refresh_scheduler_if;
  localparam int unsigned CH_N  = 2;
  localparam int unsigned BIN_W = 8;
  localparam int unsigned BCD_W = 12;

  logic [CH_N-1:0]  req;
  logic [BIN_W-1:0] bin0;
  logic [BIN_W-1:0] bin1;
  logic [CH_N-1:0]  grant;
  logic             busy;
  logic [CH_N-1:0]  done;
  logic [BCD_W-1:0] bcd0;
  logic [BCD_W-1:0] bcd1;

  // Requesting side: drives requests and operands, receives results.
  modport master (
    output req, bin0, bin1,
    input  grant, busy, done, bcd0, bcd1
  );

  // Engine side.
  modport slave (
    input  req, bin0, bin1,
    output grant, busy, done, bcd0, bcd1
  );
endinterface

// File: rtl/bcd_refresh_scheduler.sv
// Two-channel round-robin scheduler around one iterative 8-bit double-dabble engine.
module bcd_refresh_scheduler #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bcd_refresh_scheduler_if.slave     bus
);

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned DIGITS = 3;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [STEP_W-1:0]   cnt;
  logic                last_served;

  logic                win_c;
  logic [BIN_W-1:0]    operand_c;
  logic [WORK_W-1:0]   corr_c;
  logic [WORK_W-1:0]   shift_c;

  // Round-robin pick: a lone requester wins, a tie goes to the channel not served last.
  always_comb begin
    win_c = 1'b0;
    if (bus.req == 2'b10) begin
      win_c = 1'b1;
    end else if (bus.req == 2'b11) begin
      win_c = ~last_served;
    end
    operand_c = win_c ? bus.bin1 : bus.bin0;
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the whole word left.
  always_comb begin
    corr_c = work;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work[BIN_W + 4*i +: 4] >= 4'd5) begin
        corr_c[BIN_W + 4*i +: 4] = work[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    shift_c = corr_c << 1;
  end

  // Control FSM with registered handshake outputs and held per-channel results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      last_served <= RR_INIT;
      bus.grant   <= '0;
      bus.done    <= '0;
      bus.busy    <= 1'b0;
      bus.bcd0    <= '0;
      bus.bcd1    <= '0;
    end else begin
      bus.grant <= '0;
      bus.done  <= '0;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            work        <= {BCD_W'(0), operand_c};
            cnt         <= '0;
            bus.grant   <= win_c ? 2'b10 : 2'b01;
            last_served <= win_c;
            bus.busy    <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          work <= shift_c;
          cnt  <= cnt + STEP_W'(1);
          if (cnt == STEP_W'(7)) begin
            if (last_served) begin
              bus.bcd1 <= shift_c[WORK_W-1:BIN_W];
              bus.done <= 2'b10;
            end else begin
              bus.bcd0 <= shift_c[WORK_W-1:BIN_W];
              bus.done <= 2'b01;
            end
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcd_refresh_scheduler.md
Name: bcd_refresh_scheduler

Overview:
- Shares one iterative 8-bit binary-to-BCD (double-dabble) engine between two display channels.
- Each channel drives an 8-bit value. The engine converts it to three packed BCD digits ({hundreds, tens, ones}, 4 bits each, 12 bits total) for the HEX display drivers.
- A round-robin arbiter picks the channel; a small FSM runs the 8 shift/add-3 steps; the result goes into that channel's held output register.

Parameters:
- RR_INIT, 1'b1: reset value of the last-served pointer. Value 1 means channel 0 wins the first tie.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  2  per-channel conversion request, level; held until grant
- bin0  input  8  channel 0 binary operand
- bin1  input  8  channel 1 binary operand
- grant  output  2  one-hot, one-cycle acknowledge; operand captured at the same edge
- busy  output  1  high while the engine is converting (SHIFT state)
- done  output  2  one-cycle pulse; the matching bcdN is valid from this cycle on
- bcd0  output  12  channel 0 result {hund, tens, ones}, held until next channel 0 completion
- bcd1  output  12  channel 1 result, held likewise

Behaviour:
- Reset (asynchronous, any state, including mid-conversion):
  - state=IDLE.
  - grant=0, done=0, busy=0, bcd0=0, bcd1=0.
  - shift register=0, step count=0, last_served=RR_INIT.
  - A conversion in progress is abandoned; its result is never written.
- FSM states: IDLE, SHIFT.
- IDLE, at an edge with req!=0:
  - Choose the winner, capture its operand into the low 8 bits of the 20-bit work register {bcd[11:0], bin[7:0]}.
  - Clear the BCD part and the step count.
  - Register grant[winner]=1 for exactly one cycle; update last_served=winner.
  - Go to SHIFT, busy=1.
- IDLE with req==0: stay; all outputs hold, except grant and done, which return to 0.
- Arbitration:
  - One requester: it wins.
  - Both requesting: the channel other than last_served wins.
- SHIFT: each edge does one step.
  - Every BCD nibble >=5 gets +3 (all three nibbles corrected in parallel).
  - Then the whole 20-bit register shifts left by 1 and the count increments.
- At the 8th SHIFT edge:
  - bcdN <= corrected-and-shifted BCD field; done[N]=1 for one cycle.
  - busy=0; return to IDLE.
- Latency: capture edge E0, result and done visible after E8.
  - The next capture can happen at E9, so a continuously requesting channel completes every 9 cycles.
- Request rules:
  - req and binN are ignored during SHIFT. Operand changes after capture do not affect the running conversion.
  - A requester still high after its grant is treated as a new request at the next IDLE edge (continuous refresh).
  - A req pulse that drops before being sampled in IDLE is lost. No queueing.
- Width: hundreds nibble never exceeds 2 (max input 255 -> 0010_0101_0101). No overflow handling needed.
- Invariants:
  - grant and done are each at most one-hot and never asserted in the same cycle.
  - The bcd output for the non-served channel never changes.

Test Plan:
1. Reset, then req=2'b01, bin0=8'd255:
   - grant=01 one cycle after the first edge; busy for 8 cycles.
   - done=01 with bcd0=12'h255; bcd1 stays 0.
2. bin1 sweep 0, 1, 9, 10, 99, 100, 128, 200, single request each:
   - bcd1 = 000, 001, 009, 010, 099, 100, 128, 200 (hex-coded digits) respectively.
3. Both req high from reset with bin0=8'd37, bin1=8'd64:
   - Channel 0 is granted first (bcd0=12'h037); channel 1 is granted at the next IDLE edge, 9 cycles after the first grant (bcd1=12'h064).
   - Keeping both req high alternates grants 0,1,0,1.
4. req1 held high, bin1 changed from 8'd50 to 8'd77 mid-conversion:
   - The running conversion yields bcd1=12'h050.
   - The next conversion, completing 9 cycles later, yields 12'h077.
5. Assert rst_n=0 at the 4th SHIFT cycle of a channel 0 conversion of 8'd199:
   - All outputs 0 immediately (asynchronous); no done pulse.
   - After release with req0 high, a fresh conversion gives bcd0=12'h199.
6. req pulse of one cycle issued while busy: no grant; the request is dropped. bcd values are unchanged.
